uart_ctrl_rx: RTL

UART receive controller: oversamples the asynchronous serial line, detects 8N1 frames (one start bit, 8 data bits LSB first, no parity, one stop bit) and presents each received byte with a one-cycle strobe. It sits directly upstream of the message-collection stage, whose `rcv`/`data` inputs it drives. Framing errors are flagged separately and never produce a byte strobe.

---
 rtl/uart_ctrl_rx.sv | 103 ++++++++++
 1 files changed

// File: rtl/uart_ctrl_rx.sv
// uart_ctrl_rx: 8N1 UART receiver with two-flop synchronizer, mid-bit sampling,
// one-cycle byte strobe and a separate framing-error strobe.
module uart_ctrl_rx #(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic       rcv,
    output logic [7:0] data,
    output logic       busy,
    output logic       ferr
);
    localparam int DIVISOR = CLK_HZ / BAUD;
    localparam int H = DIVISOR / 2;
    localparam int TW = $clog2(DIVISOR);
    localparam logic [TW-1:0] LD_H = TW'(H - 1);
    localparam logic [TW-1:0] LD_D = TW'(DIVISOR - 1);

    if (DIVISOR < 4) begin : g_bad_divisor
        $error("uart_ctrl_rx: DIVISOR must be at least 4");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state, w_state_nx;
    logic          r_rx_m, r_rx_s, r_rx_d;
    logic [TW-1:0] r_tmr, w_tmr_nx;
    logic [2:0]    r_idx, w_idx_nx;
    logic [7:0]    r_shift, w_shift_nx, r_data, w_data_nx;
    logic          r_rcv, w_rcv_nx, r_ferr, w_ferr_nx;
    logic          w_edge, w_exp;

    assign w_edge = !r_rx_s && r_rx_d;
    assign w_exp  = (r_tmr == '0);

    // Timer counts down to zero; a reload of N-1 expires exactly N cycles later.
    always_comb begin
        w_state_nx = r_state;
        w_tmr_nx   = (r_state != IDLE && !w_exp) ? r_tmr - 1'b1 : r_tmr;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_data_nx  = r_data;
        w_rcv_nx   = 1'b0;
        w_ferr_nx  = 1'b0;
        case (r_state)
            IDLE: if (w_edge) begin
                w_state_nx = START;
                w_tmr_nx   = LD_H;
            end
            START: if (w_exp) begin
                w_state_nx = r_rx_s ? IDLE : DATA;
                w_tmr_nx   = LD_D;
                w_idx_nx   = '0;
            end
            DATA: if (w_exp) begin
                w_shift_nx = {r_rx_s, r_shift[7:1]};
                w_idx_nx   = r_idx + 1'b1;
                w_tmr_nx   = LD_D;
                w_state_nx = (r_idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (w_exp) begin
                w_state_nx = IDLE;
                w_rcv_nx   = r_rx_s;
                w_ferr_nx  = !r_rx_s;
                w_data_nx  = r_rx_s ? r_shift : r_data;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_m  <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
            r_state <= IDLE;
            r_tmr   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_rcv   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_rx_m  <= rx;
            r_rx_s  <= r_rx_m;
            r_rx_d  <= r_rx_s;
            r_state <= w_state_nx;
            r_tmr   <= w_tmr_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_data  <= w_data_nx;
            r_rcv   <= w_rcv_nx;
            r_ferr  <= w_ferr_nx;
        end
    end

    assign rcv  = r_rcv;
    assign ferr = r_ferr;
    assign data = r_data;
    assign busy = (r_state != IDLE);
endmodule
